hex_entry: RTL

Hex keypad/switch entry block for the MIPS core board I/O; the input-side counterpart of the 7-segment hex display path. Synchronises and debounces three raw pushbuttons, assembles a 32-bit word one hex nibble at a time from a 4-bit switch bank, and offers the finished word to the core over a valid/ready handshake. HEXVAL is sized to feed the existing 8-digit hex display directly, so the user sees the word while it is being typed.

---
 rtl/hex_entry.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hex_entry.sv
// Hex nibble entry: synchronised/debounced buttons build a 32-bit word offered over valid/ready.
// Optional debouncer enabled by defining HEX_ENTRY_DEBOUNCE_EN; otherwise the synchroniser output drives the edge detector.
module hex_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  SW,
  input  logic        BTN_PUSH_N,
  input  logic        BTN_CLR_N,
  input  logic        BTN_ENTER_N,
  output logic [31:0] HEXVAL,
  output logic [3:0]  NDIG,
  output logic [31:0] DOUT,
  output logic        DVALID,
  input  logic        DREADY,
  output logic        BUSY
);

  typedef enum logic {ENTRY, OFFER} state_t;

  // Bit order for all per-button vectors: [2]=enter, [1]=clr, [0]=push; 1 = pressed.
  logic [2:0] raw_pressed;
  logic [2:0] sync1, sync2;
  logic [2:0] deb, deb_q;
  logic [2:0] pulse;

  assign raw_pressed = {~BTN_ENTER_N, ~BTN_CLR_N, ~BTN_PUSH_N};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_pressed;
      sync2 <= sync1;
    end
  end

`ifdef HEX_ENTRY_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] cnt [3];

  always_ff @(posedge CLK) begin
    if (RST) begin
      deb <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign deb = sync2;
`endif

  always_ff @(posedge CLK) begin
    if (RST) deb_q <= '0;
    else     deb_q <= deb;
  end

  assign pulse = deb & ~deb_q;

  state_t      state, state_nx;
  logic [31:0] hexval_nx, dout_nx;
  logic [3:0]  ndig_nx;
  logic        dvalid_nx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ENTRY;
      HEXVAL <= '0;
      NDIG   <= '0;
      DOUT   <= '0;
      DVALID <= 1'b0;
    end else begin
      state  <= state_nx;
      HEXVAL <= hexval_nx;
      NDIG   <= ndig_nx;
      DOUT   <= dout_nx;
      DVALID <= dvalid_nx;
    end
  end

  // Priority CLR > ENTER > PUSH; anything lower in the same cycle is dropped.
  always_comb begin
    state_nx  = state;
    hexval_nx = HEXVAL;
    ndig_nx   = NDIG;
    dout_nx   = DOUT;
    dvalid_nx = DVALID;
    case (state)
      ENTRY: begin
        if (pulse[1]) begin
          hexval_nx = '0;
          ndig_nx   = '0;
        end else if (pulse[2]) begin
          if (NDIG != 4'd0) begin
            dout_nx   = HEXVAL;
            dvalid_nx = 1'b1;
            state_nx  = OFFER;
          end
        end else if (pulse[0]) begin
          hexval_nx = {HEXVAL[27:0], SW};
          ndig_nx   = (NDIG == 4'd8) ? 4'd8 : NDIG + 4'd1;
        end
      end
      OFFER: begin
        if (DREADY) begin
          dvalid_nx = 1'b0;
          hexval_nx = '0;
          ndig_nx   = '0;
          state_nx  = ENTRY;
        end
      end
      default: state_nx = ENTRY;
    endcase
  end

  assign BUSY = (state == OFFER);

endmodule
